// File: rtl/mips_pkg.sv
// Shared definitions for the 4-stage MIPS core: decoder control bundle,
// field encodings and the bubble constants used to kill pipeline slots.
package mips_pkg;

    // RegDst encodings: which instruction field names the destination
    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_RA   = 2'd2;
    localparam logic [1:0] REGDST_ZERO = 2'd3;

    // MemToReg encodings: write-back source select
    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_LUI = 2'd2;
    localparam logic [1:0] MEMTOREG_PC4 = 2'd3;

    // ALUOp constants handed to the ALU controller
    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE = 3'd2;
    localparam logic [2:0] ALUOP_AND   = 3'd3;
    localparam logic [2:0] ALUOP_OR    = 3'd4;
    localparam logic [2:0] ALUOP_SLT   = 3'd5;
    localparam logic [2:0] ALUOP_XOR   = 3'd6;

    // Link register written by jal
    localparam int REG_RA = 31;

    // Control fields that travel on into EX
    typedef struct packed {
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
        logic       jump;
        logic       branch_z;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       store_src;
        logic       bne;
    } ex_ctrl_t;

    // Full decoder bundle; reg_dst is consumed by the destination resolve in ID/EX
    typedef struct packed {
        logic [1:0] reg_dst;
        ex_ctrl_t   ex;
    } ctrl_t;

    // All-zero bundles: a bubble performs no write, no memory access, no redirect
    localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;
    localparam ctrl_t    CTRL_BUBBLE    = '0;

    // Load-use interlock FSM states
    typedef enum logic {
        HZ_RUN    = 1'b0,
        HZ_BUBBLE = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector with its RUN/BUBBLE interlock FSM.
// Compiled only when ID_EX_LOAD_USE_STALL_EN is defined.
`ifdef ID_EX_LOAD_USE_STALL_EN
module hazard_detect_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic              id_alu_src_i,
    input  logic              id_mem_write_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_write_reg_i,
    output logic              hazard_o,
    output logic              stall_o
);

    hz_state_e state_q, state_d;
    logic      uses_rt;
    logic      load_use;

    // Raw load-use condition: a live load in EX targets a register the ID op reads
    always_comb begin
        uses_rt  = !id_alu_src_i || id_mem_write_i;
        load_use = ex_valid_i && ex_mem_read_i && (ex_write_reg_i != '0) && id_valid_i &&
                   ((ex_write_reg_i == id_rs_i) || (uses_rt && (ex_write_reg_i == id_rt_i)));
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one bubble per pair, then back to RUN; flush always returns to RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_RUN:    if (hazard_o) state_d = HZ_BUBBLE;
            HZ_BUBBLE: state_d = HZ_RUN;
            default:   state_d = HZ_RUN;
        endcase
        if (flush_i) state_d = HZ_RUN;
    end

    // Outputs: bubble request, and the stall that is suppressed by flush/reset
    always_comb begin
        hazard_o = load_use && (state_q == HZ_RUN);
        stall_o  = hazard_o && !flush_i && !rst_i;
    end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded bundle, operands, immediate and
// PC+4, resolves the destination register, and inserts bubbles on flush or
// load-use hazard. Load-use interlock is built only with ID_EX_LOAD_USE_STALL_EN;
// without it stall is tied low and software must fill the load delay slot.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [1:0]        id_reg_dst,
    input  logic [1:0]        id_mem_to_reg,
    input  logic [2:0]        id_alu_op,
    input  logic              id_jump,
    input  logic              id_branch_z,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_store_src,
    input  logic              id_bne,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic [1:0]        ex_mem_to_reg,
    output logic [2:0]        ex_alu_op,
    output logic              ex_jump,
    output logic              ex_branch_z,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_store_src,
    output logic              ex_bne,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic              ex_valid,
    output logic              stall
);

    ctrl_t             id_ctrl;
    logic [REG_AW-1:0] dest;
    logic              hz_bubble;
    logic              load_bubble;

    ex_ctrl_t          ctrl_q,     ctrl_d;
    logic [REG_AW-1:0] rs_q,       rs_d;
    logic [REG_AW-1:0] rt_q,       rt_d;
    logic [REG_AW-1:0] wr_q,       wr_d;
    logic [DATA_W-1:0] rs_data_q,  rs_data_d;
    logic [DATA_W-1:0] rt_data_q,  rt_data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [DATA_W-1:0] pc4_q,      pc4_d;
    logic              valid_q,    valid_d;

    // Gather the decoder flags into one bundle
    always_comb begin
        id_ctrl               = CTRL_BUBBLE;
        id_ctrl.reg_dst       = id_reg_dst;
        id_ctrl.ex.mem_to_reg = id_mem_to_reg;
        id_ctrl.ex.alu_op     = id_alu_op;
        id_ctrl.ex.jump       = id_jump;
        id_ctrl.ex.branch_z   = id_branch_z;
        id_ctrl.ex.mem_read   = id_mem_read;
        id_ctrl.ex.mem_write  = id_mem_write;
        id_ctrl.ex.alu_src    = id_alu_src;
        id_ctrl.ex.reg_write  = id_reg_write;
        id_ctrl.ex.store_src  = id_store_src;
        id_ctrl.ex.bne        = id_bne;
    end

    // Destination register resolve from RegDst
    always_comb begin
        case (id_ctrl.reg_dst)
            REGDST_RT: dest = id_rt;
            REGDST_RD: dest = id_rd;
            REGDST_RA: dest = REG_AW'(REG_RA);
            default:   dest = '0;
        endcase
    end

`ifdef ID_EX_LOAD_USE_STALL_EN
    hazard_detect_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .id_valid_i     (id_valid),
        .id_alu_src_i   (id_alu_src),
        .id_mem_write_i (id_mem_write),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .ex_valid_i     (valid_q),
        .ex_mem_read_i  (ctrl_q.mem_read),
        .ex_write_reg_i (wr_q),
        .hazard_o       (hz_bubble),
        .stall_o        (stall)
    );
`else
    assign hz_bubble = 1'b0;
    assign stall     = 1'b0;
`endif

    assign load_bubble = flush || hz_bubble;

    // Next EX contents: bubble on flush/hazard, else the ID instruction with
    // control squashed when ID is empty and reg_write dropped for $0
    always_comb begin
        ctrl_d    = EX_CTRL_BUBBLE;
        rs_d      = '0;
        rt_d      = '0;
        wr_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        pc4_d     = '0;
        valid_d   = 1'b0;
        if (!load_bubble) begin
            if (id_valid) ctrl_d = id_ctrl.ex;
            ctrl_d.reg_write = id_valid && id_reg_write && (dest != '0);
            rs_d      = id_rs;
            rt_d      = id_rt;
            wr_d      = dest;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            pc4_d     = id_pc4;
            valid_d   = id_valid;
        end
    end

    // ID/EX pipeline register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= EX_CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            wr_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            wr_q      <= wr_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
        end
    end

    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_jump       = ctrl_q.jump;
    assign ex_branch_z   = ctrl_q.branch_z;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_store_src  = ctrl_q.store_src;
    assign ex_bne        = ctrl_q.bne;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_imm        = imm_q;
    assign ex_pc4        = pc4_q;
    assign ex_write_reg  = wr_q;
    assign ex_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random instruction streams,
// each cycle checked against an instruction-level model of the EX slot.
module tb_id_ex_stage;

`ifdef ID_EX_LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic id_valid;
    logic [1:0] id_reg_dst, id_mem_to_reg;
    logic [2:0] id_alu_op;
    logic id_jump, id_branch_z, id_mem_read, id_mem_write;
    logic id_alu_src, id_reg_write, id_store_src, id_bne;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic flush;

    logic [1:0] ex_mem_to_reg;
    logic [2:0] ex_alu_op;
    logic ex_jump, ex_branch_z, ex_mem_read, ex_mem_write;
    logic ex_alu_src, ex_reg_write, ex_store_src, ex_bne;
    logic [4:0] ex_rs, ex_rt, ex_write_reg;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic ex_valid, stall;

    int n_vec = 0;
    int n_err = 0;

    // Expected contents of the EX slot
    typedef struct {
        logic [1:0]  m2r;
        logic [2:0]  aluop;
        logic        jump, bz, mr, mw, asrc, rw, ss, bne;
        logic [4:0]  rs, rt, wr;
        logic [31:0] rsd, rtd, imm, pc4;
        logic        v;
    } exp_t;
    exp_t m;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_reg_dst(id_reg_dst), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
        .id_jump(id_jump), .id_branch_z(id_branch_z), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_store_src(id_store_src), .id_bne(id_bne),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_jump(ex_jump),
        .ex_branch_z(ex_branch_z), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_store_src(ex_store_src),
        .ex_bne(ex_bne), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ex();
        chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
        chk("ex_alu_op",     32'(ex_alu_op),     32'(m.aluop));
        chk("ex_jump",       32'(ex_jump),       32'(m.jump));
        chk("ex_branch_z",   32'(ex_branch_z),   32'(m.bz));
        chk("ex_mem_read",   32'(ex_mem_read),   32'(m.mr));
        chk("ex_mem_write",  32'(ex_mem_write),  32'(m.mw));
        chk("ex_alu_src",    32'(ex_alu_src),    32'(m.asrc));
        chk("ex_reg_write",  32'(ex_reg_write),  32'(m.rw));
        chk("ex_store_src",  32'(ex_store_src),  32'(m.ss));
        chk("ex_bne",        32'(ex_bne),        32'(m.bne));
        chk("ex_rs",         32'(ex_rs),         32'(m.rs));
        chk("ex_rt",         32'(ex_rt),         32'(m.rt));
        chk("ex_write_reg",  32'(ex_write_reg),  32'(m.wr));
        chk("ex_rs_data",    ex_rs_data,         m.rsd);
        chk("ex_rt_data",    ex_rt_data,         m.rtd);
        chk("ex_imm",        ex_imm,             m.imm);
        chk("ex_pc4",        ex_pc4,             m.pc4);
        chk("ex_valid",      32'(ex_valid),      32'(m.v));
    endtask

    // One cycle: predict stall from the instruction in EX vs the one in ID,
    // clock, then predict what EX holds.
    task automatic step();
        logic [4:0] dest;
        logic reads_rt, haz, exp_stall;
        case (id_reg_dst)
            2'd0:    dest = id_rt;
            2'd1:    dest = id_rd;
            2'd2:    dest = 5'd31;
            default: dest = 5'd0;
        endcase
        reads_rt  = !id_alu_src || id_mem_write;
        haz = STALL_EN && m.v && m.mr && (m.wr != 5'd0) && id_valid &&
              ((m.wr == id_rs) || (reads_rt && (m.wr == id_rt)));
        exp_stall = haz && !flush && !rst;
        #1;
        chk("stall", 32'(stall), 32'(exp_stall));
        @(posedge clk);
        if (rst || flush || haz) begin
            m = '{default: '0};
        end else begin
            m.m2r   = id_valid ? id_mem_to_reg : 2'd0;
            m.aluop = id_valid ? id_alu_op : 3'd0;
            m.jump  = id_valid && id_jump;
            m.bz    = id_valid && id_branch_z;
            m.mr    = id_valid && id_mem_read;
            m.mw    = id_valid && id_mem_write;
            m.asrc  = id_valid && id_alu_src;
            m.rw    = id_valid && id_reg_write && (dest != 5'd0);
            m.ss    = id_valid && id_store_src;
            m.bne   = id_valid && id_bne;
            m.rs    = id_rs;
            m.rt    = id_rt;
            m.wr    = dest;
            m.rsd   = id_rs_data;
            m.rtd   = id_rt_data;
            m.imm   = id_imm;
            m.pc4   = id_pc4;
            m.v     = id_valid;
        end
        #1;
        check_ex();
    endtask

    task automatic clear_id();
        rst = 0; flush = 0; id_valid = 0;
        id_reg_dst = 0; id_mem_to_reg = 0; id_alu_op = 0;
        id_jump = 0; id_branch_z = 0; id_mem_read = 0; id_mem_write = 0;
        id_alu_src = 0; id_reg_write = 0; id_store_src = 0; id_bne = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_pc4 = 0;
    endtask

    task automatic set_lw4();
        clear_id();
        id_valid = 1; id_reg_dst = 2'd0; id_mem_to_reg = 2'd1; id_mem_read = 1;
        id_alu_src = 1; id_reg_write = 1; id_rs = 5'd1; id_rt = 5'd4; id_imm = 32'h10;
    endtask

    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_id();
        id_valid = 1; id_reg_dst = 2'd1; id_alu_op = 3'd2; id_reg_write = 1;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = $urandom; id_rt_data = $urandom; id_pc4 = 32'h0040_0010;
    endtask

    task automatic drive_rand();
        id_valid      = ($urandom % 8) != 0;
        id_reg_dst    = 2'($urandom);
        id_mem_to_reg = 2'($urandom);
        id_alu_op     = 3'($urandom);
        id_jump       = 1'($urandom);
        id_branch_z   = 1'($urandom);
        id_mem_read   = ($urandom % 3) == 0;
        id_mem_write  = 1'($urandom);
        id_alu_src    = 1'($urandom);
        id_reg_write  = ($urandom % 4) != 0;
        id_store_src  = 1'($urandom);
        id_bne        = 1'($urandom);
        id_rs         = 5'($urandom_range(0, 5));
        id_rt         = 5'($urandom_range(0, 5));
        id_rd         = 5'($urandom_range(0, 5));
        id_rs_data    = $urandom;
        id_rt_data    = $urandom;
        id_imm        = $urandom;
        id_pc4        = $urandom;
        flush         = ($urandom % 10) == 0;
        rst           = ($urandom % 40) == 0;
    endtask

    initial begin
        m = '{default: '0};
        clear_id();

        // Reset
        rst = 1;
        step();
        step();

        // add $3 <- $1 + $2
        set_add(5'd1, 5'd2, 5'd3);
        step();
        chk("add_write_reg", 32'(ex_write_reg), 32'd3);
        chk("add_reg_write", 32'(ex_reg_write), 32'd1);
        chk("add_valid",     32'(ex_valid),     32'd1);

        // jal
        clear_id();
        id_valid = 1; id_reg_dst = 2'd2; id_mem_to_reg = 2'd3; id_jump = 1;
        id_reg_write = 1; id_pc4 = 32'h0040_0008;
        step();
        chk("jal_write_reg", 32'(ex_write_reg), 32'd31);
        chk("jal_pc4",       ex_pc4,            32'h0040_0008);

        // RegDst 3 resolves to $0 and drops reg_write
        clear_id();
        id_valid = 1; id_reg_dst = 2'd3; id_reg_write = 1; id_rd = 5'd9;
        step();
        chk("zero_dest_rw", 32'(ex_reg_write), 32'd0);

        // lw $4 then dependent add $5 <- $4 + $6: one bubble, then the add
        set_lw4();
        step();
        set_add(5'd4, 5'd6, 5'd5);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'(!STALL_EN));
        step();
        chk("lu_add_arrives", 32'(ex_write_reg), 32'd5);
        chk("lu_no_2nd_stall", 32'(stall), 32'd0);

        // lw $4 then addi reading rs=$7, writing rt=$4: no rt use, no stall
        set_lw4();
        step();
        clear_id();
        id_valid = 1; id_alu_src = 1; id_reg_write = 1; id_rs = 5'd7; id_rt = 5'd4;
        id_imm = 32'h5;
        step();
        chk("addi_valid", 32'(ex_valid), 32'd1);

        // Back-to-back independent loads
        set_lw4();
        step();
        set_lw4();
        id_rs = 5'd2; id_rt = 5'd8;
        step();
        chk("lw_lw_valid", 32'(ex_valid), 32'd1);

        // lw $4 then dependent add with flush in the same cycle
        set_lw4();
        step();
        set_add(5'd4, 5'd6, 5'd5);
        flush = 1;
        step();
        chk("flush_bubble", 32'(ex_valid), 32'd0);
        flush = 0;

        // lw $4 then dependent add with reset asserted
        set_lw4();
        step();
        set_add(5'd6, 5'd4, 5'd5);
        rst = 1;
        step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_wr",    32'(ex_write_reg), 32'd0);
        chk("rst_pc4",   ex_pc4, 32'd0);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
